// File: rtl/pulse_width_meter.sv
// -----------------------------------------------------------------------------
// pulse_width_meter
//
// Measures the high-time of a signal, in CLK cycles, from the single-cycle
// rising/falling edge pulses (RE/FE) of an upstream edge-detect stage.
// Each accepted pulse produces one result word on a VALID/READY handshake.
//
// Features:
//   - saturating width counter (max 2^CNT_W-1, flagged on SAT)
//   - minimum-width glitch filter (pulses shorter than MIN_W are dropped)
//   - sticky overrun flag (OVR) when an unconsumed result is overwritten
//
// Optional build macro:
//   PWM_PERIOD_MEAS_EN - adds the PERIOD output, which reports the
//                        RE-to-RE distance for the pulse just captured.
// -----------------------------------------------------------------------------
module pulse_width_meter #(
    parameter int CNT_W = 16,
    parameter int MIN_W = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             RE,
    input  logic             FE,
    input  logic             READY,
    output logic             VALID,
    output logic [CNT_W-1:0] WIDTH,
    output logic             SAT,
    output logic             OVR,
    output logic             BUSY
`ifdef PWM_PERIOD_MEAS_EN
    ,
    output logic [CNT_W-1:0] PERIOD
`endif
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;
    logic             capture;
    logic             xfer;

    // The counter saturates at its maximum, so "at max" is the same as
    // "true width has reached or exceeded the maximum".
    assign cnt_sat = (cnt == CNT_MAX);

    // A result is produced only when a timed pulse ends and passes the filter.
    assign capture = (state == ST_HIGH) && FE && (cnt >= MIN_CNT);

    // A handshake transfer happens whenever a held result meets READY.
    assign xfer = VALID && READY;

    // BUSY is a direct decode of the state register, so it is glitch-free.
    assign BUSY = (state == ST_HIGH);

    // Pulse timing FSM and saturating width counter.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // FE here is ignored: covers an input already high out of reset.
                    if (RE) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (FE) begin
                        if (RE) begin
                            // Fall and new rise in the same cycle: keep timing.
                            cnt <= CNT_ONE;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end else if (RE) begin
                        // A second rise without a fall: restart, no result.
                        cnt <= CNT_ONE;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Result registers, VALID/READY handshake and sticky overrun flag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            VALID <= 1'b0;
            WIDTH <= '0;
            SAT   <= 1'b0;
            OVR   <= 1'b0;
        end else if (capture) begin
            VALID <= 1'b1;
            WIDTH <= cnt;
            SAT   <= cnt_sat;
            if (VALID && !READY) begin
                // The previous result is lost without ever being consumed.
                OVR <= 1'b1;
            end else if (xfer) begin
                // The previous result leaves as the new one arrives.
                OVR <= 1'b0;
            end
        end else if (xfer) begin
            VALID <= 1'b0;
            OVR   <= 1'b0;
        end
    end

`ifdef PWM_PERIOD_MEAS_EN
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_latch;

    // Free RE-to-RE counter: idle at 0 until the first RE, so the first
    // pulse after reset reports a period of 0. Its value is latched on RE.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            period_cnt   <= '0;
            period_latch <= '0;
        end else if (RE) begin
            period_cnt   <= CNT_ONE;
            period_latch <= period_cnt;
        end else if ((period_cnt != '0) && (period_cnt != CNT_MAX)) begin
            period_cnt <= period_cnt + CNT_ONE;
        end
    end

    // PERIOD is published together with WIDTH for the pulse being captured.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            PERIOD <= '0;
        end else if (capture) begin
            PERIOD <= period_latch;
        end
    end
`else
    // Period measurement not built: no PERIOD port and no period counter.
`endif

endmodule
